// File: rtl/ift_mon_pkg.sv
// Shared types and helpers for the taint monitor: FSM states, the event
// record layout, and a width-aware saturating increment.
package ift_mon_pkg;

    localparam int DW_DEF = 2;
    localparam int TW_DEF = 32;
    localparam int CW_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Field order matches the {ts, Q, Q_t} packing used on EV_DATA.
    typedef struct packed {
        logic [CW_DEF-1:0] ts;
        logic [DW_DEF-1:0] q;
        logic [TW_DEF-1:0] q_t;
    } ift_event_t;

    // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ift_event_fifo.sv
// Event FIFO with extra-MSB pointers; a push into a full FIFO only lands
// when a pop happens in the same cycle, otherwise it is reported as dropped.
module ift_event_fifo
    import ift_mon_pkg::*;
#(
    parameter int W     = 50,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         ARST,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         pop;
    logic         wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = !empty;
    assign pop   = valid && ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge ARST) begin
        if (!ARST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ift_taint_monitor.sv
// Observer for an IFT-instrumented register stage: accumulates taint stats
// while armed and queues {ts, Q, Q_t} whenever the taint label changes.
module ift_taint_monitor
    import ift_mon_pkg::*;
#(
    parameter int DW    = 2,
    parameter int TW    = 32,
    parameter int CW    = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             START,
    input  logic             STOP,
    input  logic [DW-1:0]    Q,
    input  logic [TW-1:0]    Q_t,
    output logic             EV_VALID,
    input  logic             EV_READY,
    output logic [CW+DW+TW-1:0] EV_DATA,
    output logic [TW-1:0]    TAINT_ACC,
    output logic [CW-1:0]    TAINT_CNT,
    output logic [CW-1:0]    FIRST_TS,
    output logic             FIRST_SEEN,
    output logic             OVERFLOW,
    output logic             BUSY
);

    state_t        state_q, state_d;
    logic [CW-1:0] ts;
    logic [TW-1:0] prev_t;
    logic          sample;
    logic          push;
    logic          drop;
    logic          full;

    always_ff @(posedge CLK or negedge ARST) begin
        if (!ARST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (START)                      state_d = ARMED;
        else if (STOP && state_q == ARMED) state_d = IDLE;
    end

    assign BUSY = (state_q == ARMED);

    // START and STOP cycles both suppress sampling.
    assign sample = (state_q == ARMED) && !START && !STOP;
    assign push   = sample && (Q_t != prev_t);

    always_ff @(posedge CLK or negedge ARST) begin
        if (!ARST) begin
            ts         <= '0;
            prev_t     <= '0;
            TAINT_ACC  <= '0;
            TAINT_CNT  <= '0;
            FIRST_TS   <= '0;
            FIRST_SEEN <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else if (START) begin
            ts         <= '0;
            prev_t     <= '0;
            TAINT_ACC  <= '0;
            TAINT_CNT  <= '0;
            FIRST_TS   <= '0;
            FIRST_SEEN <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else if (sample) begin
            ts        <= CW'(sat_inc(32'(ts), CW));
            prev_t    <= Q_t;
            TAINT_ACC <= TAINT_ACC | Q_t;
            if (|Q_t) begin
                TAINT_CNT <= CW'(sat_inc(32'(TAINT_CNT), CW));
                if (!FIRST_SEEN) begin
                    FIRST_SEEN <= 1'b1;
                    FIRST_TS   <= ts;
                end
            end
            if (drop) OVERFLOW <= 1'b1;
        end
    end

    ift_event_fifo #(
        .W     (CW + DW + TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .ARST  (ARST),
        .push  (push),
        .din   ({ts, Q, Q_t}),
        .ready (EV_READY),
        .valid (EV_VALID),
        .dout  (EV_DATA),
        .full  (full),
        .drop  (drop)
    );

endmodule

// File: tb/tb_ift_taint_monitor.sv
// Directed bench for the taint monitor: reset, taint window, overflow,
// full push+pop, re-arm priority and mid-run asynchronous reset.
module tb_ift_taint_monitor;
    import ift_mon_pkg::*;

    logic        CLK = 1'b0;
    logic        ARST;
    logic        START, STOP, EV_READY;
    logic [1:0]  Q;
    logic [31:0] Q_t;
    logic        EV_VALID, FIRST_SEEN, OVERFLOW, BUSY;
    logic [49:0] EV_DATA;
    logic [31:0] TAINT_ACC;
    logic [15:0] TAINT_CNT, FIRST_TS;

    int n_checks = 0;
    int n_fail   = 0;

    ift_taint_monitor #(.DW(2), .TW(32), .CW(16), .DEPTH(4)) dut (
        .CLK(CLK), .ARST(ARST), .START(START), .STOP(STOP), .Q(Q), .Q_t(Q_t),
        .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_DATA(EV_DATA),
        .TAINT_ACC(TAINT_ACC), .TAINT_CNT(TAINT_CNT), .FIRST_TS(FIRST_TS),
        .FIRST_SEEN(FIRST_SEEN), .OVERFLOW(OVERFLOW), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input string tag, input logic [15:0] ts, input logic [1:0] q,
                            input logic [31:0] qt);
        ift_event_t e;
        e.ts  = ts;
        e.q   = q;
        e.q_t = qt;
        check({tag, "_valid"}, 64'(EV_VALID), 64'd1);
        check(tag, 64'(EV_DATA), 64'(e));
    endtask

    task automatic check_stats_zero(input string tag);
        check({tag, "_acc"},   64'(TAINT_ACC),  64'd0);
        check({tag, "_cnt"},   64'(TAINT_CNT),  64'd0);
        check({tag, "_fts"},   64'(FIRST_TS),   64'd0);
        check({tag, "_fseen"}, 64'(FIRST_SEEN), 64'd0);
        check({tag, "_ovf"},   64'(OVERFLOW),   64'd0);
    endtask

    initial begin
        ARST = 1'b0; START = 1'b1; STOP = 1'b0; EV_READY = 1'b0; Q = 2'd0; Q_t = 32'd0;

        // Reset held, START ignored
        step(); step();
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_valid", 64'(EV_VALID), 64'd0);
        check("rst_data", 64'(EV_DATA), 64'd0);
        ARST = 1'b1; START = 1'b0;
        step();
        check("rel_busy", 64'(BUSY), 64'd0);
        check("rel_valid", 64'(EV_VALID), 64'd0);
        check_stats_zero("rel");
        Q_t = 32'hFF; Q = 2'd3;
        step(); step(); step();
        check("idle_busy", 64'(BUSY), 64'd0);
        check("idle_valid", 64'(EV_VALID), 64'd0);
        check_stats_zero("idle");

        // Single taint window
        START = 1'b1; step(); START = 1'b0;
        check("win_busy", 64'(BUSY), 64'd1);
        Q_t = 32'h0; Q = 2'd1; step();          // ts0
        Q_t = 32'h0;           step();          // ts1
        check("win_novalid", 64'(EV_VALID), 64'd0);
        Q_t = 32'h4; Q = 2'd2; step();          // ts2 event
        check_ev("win_ev_early", 16'd2, 2'd2, 32'h4);
        Q_t = 32'h4;           step();          // ts3
        Q_t = 32'h0; Q = 2'd3; step();          // ts4 event
        STOP = 1'b1; Q_t = 32'h8; step(); STOP = 1'b0;
        check("win_busy_off", 64'(BUSY), 64'd0);
        check("win_acc", 64'(TAINT_ACC), 64'h4);
        check("win_cnt", 64'(TAINT_CNT), 64'd2);
        check("win_fts", 64'(FIRST_TS), 64'd2);
        check("win_fseen", 64'(FIRST_SEEN), 64'd1);
        step(); step();
        check("win_hold_acc", 64'(TAINT_ACC), 64'h4);
        check("win_hold_cnt", 64'(TAINT_CNT), 64'd2);
        check_ev("win_ev0", 16'd2, 2'd2, 32'h4);
        EV_READY = 1'b1; step();
        check_ev("win_ev1", 16'd4, 2'd3, 32'h0);
        step();
        check("win_empty", 64'(EV_VALID), 64'd0);
        EV_READY = 1'b0;

        // Overflow: six changes, four slots
        START = 1'b1; step(); START = 1'b0;
        for (int i = 0; i < 6; i++) begin
            Q = 2'(i); Q_t = (i % 2 == 0) ? 32'h1 : 32'h2;
            step();
        end
        check("ovf_flag", 64'(OVERFLOW), 64'd1);
        STOP = 1'b1; step(); STOP = 1'b0;
        check("ovf_busy", 64'(BUSY), 64'd0);
        check("ovf_stable", 64'(EV_DATA), 64'({16'd0, 2'd0, 32'h1}));
        EV_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_ev("ovf_drain", 16'(i), 2'(i), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end
        check("ovf_empty", 64'(EV_VALID), 64'd0);
        EV_READY = 1'b0;

        // Full FIFO with simultaneous push and pop
        START = 1'b1; step(); START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Q = 2'(i); Q_t = (i % 2 == 0) ? 32'h1 : 32'h2;
            step();
        end
        check("pp_noovf_full", 64'(OVERFLOW), 64'd0);
        Q = 2'd3; Q_t = 32'h1; EV_READY = 1'b1; step();   // ts4 push + pop
        EV_READY = 1'b0; step();                           // ts5 no change
        check("pp_noovf", 64'(OVERFLOW), 64'd0);
        STOP = 1'b1; step(); STOP = 1'b0;
        EV_READY = 1'b1;
        check_ev("pp_ev1", 16'd1, 2'd1, 32'h2); step();
        check_ev("pp_ev2", 16'd2, 2'd2, 32'h1); step();
        check_ev("pp_ev3", 16'd3, 2'd3, 32'h2); step();
        check_ev("pp_ev4", 16'd4, 2'd3, 32'h1); step();
        check("pp_empty", 64'(EV_VALID), 64'd0);
        EV_READY = 1'b0;

        // Re-arm with START and STOP together
        START = 1'b1; step(); START = 1'b0;
        Q = 2'd1; Q_t = 32'h1;
        repeat (5) step();
        check("ra_cnt5", 64'(TAINT_CNT), 64'd5);
        START = 1'b1; STOP = 1'b1; step(); START = 1'b0; STOP = 1'b0;
        check("ra_busy", 64'(BUSY), 64'd1);
        check("ra_cnt0", 64'(TAINT_CNT), 64'd0);
        check("ra_fseen0", 64'(FIRST_SEEN), 64'd0);
        check_ev("ra_kept", 16'd0, 2'd1, 32'h1);
        Q = 2'd2; Q_t = 32'h3; step();                     // ts restarts at 0
        check("ra_fseen", 64'(FIRST_SEEN), 64'd1);
        check("ra_fts", 64'(FIRST_TS), 64'd0);
        check("ra_cnt1", 64'(TAINT_CNT), 64'd1);
        check("ra_acc", 64'(TAINT_ACC), 64'h3);
        Q_t = 32'h0; step();                               // third queued event

        // Asynchronous reset between edges
        #2 ARST = 1'b0;
        #1;
        check("ar_valid", 64'(EV_VALID), 64'd0);
        check("ar_busy", 64'(BUSY), 64'd0);
        check("ar_cnt", 64'(TAINT_CNT), 64'd0);
        #3 ARST = 1'b1;
        step();
        check("ar_rel_valid", 64'(EV_VALID), 64'd0);
        check("ar_rel_busy", 64'(BUSY), 64'd0);
        check_stats_zero("ar_rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
